// File: rtl/eth_decap_if.sv
// AXI-Stream beat bundle between the 10G MAC RX side and the decapsulator.
interface eth_decap_if;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/eth_decap.sv
// Eth+IPv4+UDP+TCAP receive decapsulator: checks the 6-beat header, strips it,
// writes the TLP beats to the replay FIFO. ETH_DECAP_IPCHECK_EN adds the IPv4 checksum check.
module eth_decap #(
  parameter logic [47:0] eth_addr  = 48'h00_11_22_33_44_55,
  parameter logic [15:0] udp_dport = 16'h3776,
  parameter int          hdr_beats = 6
) (
  input  logic          clk156,
  input  logic          sys_rst_n,
  eth_decap_if.slave    s_axis,
  output logic          wr_en,
  output logic [73:0]   din,
  input  logic          full,
  output logic [39:0]   ts_out,
  output logic          ts_valid,
  output logic [31:0]   stat_rx_frames,
  output logic [31:0]   stat_drop_frames
);
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DROP} state_t;

  state_t          state, state_nxt;
  logic [2:0]      beat_cnt;
  logic            drop_flag, quiet;
  logic [7:0][7:0] b;
  logic [47:0]     dst;
  logic            xfer, last_hdr, fld_bad, hdr_bad;

  assign b        = s_axis.tdata;
  assign dst      = {b[0], b[1], b[2], b[3], b[4], b[5]};
  assign xfer     = s_axis.tvalid && s_axis.tready;
  assign last_hdr = beat_cnt == 3'(hdr_beats - 1);

`ifdef ETH_DECAP_IPCHECK_EN
  logic [19:0] csum_acc, csum_nxt;
  logic [16:0] csum_fold;
  logic        csum_bad;

  // IP header bytes 14..33 as big-endian 16-bit words
  always_comb begin
    csum_nxt = csum_acc;
    case (beat_cnt)
      3'd0:       csum_nxt = '0;
      3'd1:       csum_nxt = csum_acc + 20'({b[6], b[7]});
      3'd2, 3'd3: csum_nxt = csum_acc + 20'({b[0], b[1]}) + 20'({b[2], b[3]})
                                      + 20'({b[4], b[5]}) + 20'({b[6], b[7]});
      3'd4:       csum_nxt = csum_acc + 20'({b[0], b[1]});
      default:    csum_nxt = csum_acc;
    endcase
  end

  assign csum_fold = 17'(csum_nxt[15:0]) + 17'(csum_nxt[19:16]);
  assign csum_bad  = csum_fold != 17'h0_FFFF;

  always_ff @(posedge clk156 or negedge sys_rst_n)
    if (!sys_rst_n)                    csum_acc <= '0;
    else if (state == S_HDR && xfer)   csum_acc <= csum_nxt;
`endif

  always_comb begin
    fld_bad = 1'b0;
    case (beat_cnt)
      3'd0:    fld_bad = !(dst == eth_addr || dst == '1);
      3'd1:    fld_bad = {b[4], b[5]} != 16'h0800;
      3'd2:    fld_bad = b[7] != 8'h11;
`ifdef ETH_DECAP_IPCHECK_EN
      3'd4:    fld_bad = ({b[4], b[5]} != udp_dport) || csum_bad;
`else
      3'd4:    fld_bad = {b[4], b[5]} != udp_dport;
`endif
      default: fld_bad = 1'b0;
    endcase
  end
  assign hdr_bad = drop_flag || fld_bad;

  always_ff @(posedge clk156 or negedge sys_rst_n)
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nxt;

  // A beat taken in S_IDLE is the tail of a frame cut by reset
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = (xfer && !s_axis.tlast) ? S_DROP : S_HDR;
      S_HDR:   if (xfer && !s_axis.tlast && last_hdr) state_nxt = hdr_bad ? S_DROP : S_DATA;
      S_DATA,
      S_DROP:  if (xfer && s_axis.tlast) state_nxt = S_HDR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    s_axis.tready = sys_rst_n && (state != S_DATA || !full);
    wr_en         = (state == S_DATA) && s_axis.tvalid && !full;
    din           = (state == S_DATA) ? {s_axis.tkeep, s_axis.tdata, s_axis.tlast, s_axis.tuser} : '0;
  end

  always_ff @(posedge clk156 or negedge sys_rst_n)
    if (!sys_rst_n) begin
      beat_cnt         <= '0;
      drop_flag        <= 1'b0;
      quiet            <= 1'b0;
      ts_out           <= '0;
      ts_valid         <= 1'b0;
      stat_rx_frames   <= '0;
      stat_drop_frames <= '0;
    end else begin
      ts_valid <= 1'b0;
      case (state)
        S_IDLE: quiet <= xfer && !s_axis.tlast;
        S_HDR: if (xfer) begin
          if (s_axis.tlast) begin
            beat_cnt         <= '0;
            drop_flag        <= 1'b0;
            stat_drop_frames <= stat_drop_frames + 32'd1;
          end else if (last_hdr) begin
            beat_cnt  <= '0;
            drop_flag <= 1'b0;
            if (!hdr_bad) begin
              ts_out   <= {b[3], b[4], b[5], b[6], b[7]};
              ts_valid <= 1'b1;
            end
          end else begin
            beat_cnt  <= beat_cnt + 3'd1;
            drop_flag <= hdr_bad;
          end
        end
        S_DATA: if (xfer && s_axis.tlast) stat_rx_frames <= stat_rx_frames + 32'd1;
        S_DROP: if (xfer && s_axis.tlast) begin
          if (!quiet) stat_drop_frames <= stat_drop_frames + 32'd1;
          quiet <= 1'b0;
        end
        default: ;
      endcase
    end
endmodule
